sram_bridge: RTL and testbench

Bus slave that turns the shared system bus (the multiplexed address, data, write-enable and chip-select output by the CPU/UART-master arbiter) into timed cycles on an external asynchronous byte-wide SRAM. It returns read data and a one-cycle acknowledge to whichever master currently owns the bus. It sits directly downstream of the bus arbiter in the computer top level, and its acknowledge feeds the arbiter's `i_ack`.

---
 rtl/sram_bridge_pkg.sv | 18 +
 rtl/sram_bridge.sv | 127 ++++++++++++
 tb/tb_sram_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the bus-to-asynchronous-SRAM bridge: the cycle
// phase encoding and the limits of the strobe-stretch counter.
package sram_bridge_pkg;

   // One SRAM access walks IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Width of the strobe down-counter and the largest stretch it can hold.
   localparam int CNT_W           = 4;
   localparam int MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/sram_bridge.sv
// Bus slave that converts arbiter bus requests into setup/strobe/hold cycles
// on an external asynchronous byte-wide SRAM and returns a one-cycle ack.
// Every pad-facing output is a flop, so the bus inputs never reach the pads
// through combinational logic. The tristate buffer itself lives at the top level.
module sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [15:0]       i_addr,
   input  logic [7:0]        i_dat,
   output logic [7:0]        o_dat,
   input  logic              i_we,
   input  logic              i_cs,
   output logic              o_ack,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [7:0]        o_sram_dq,
   output logic              o_sram_dq_oe,
   input  logic [7:0]        i_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n
);

   // The reload value is clamped so that an out-of-range parameter cannot
   // wrap the counter.
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      CNT_W'((WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [15:0]      last_addr;
   logic             last_we;
   logic             prev_cs;
   logic             req_match;
   logic             req_new;

   // A request is new after a gap in chip select, or when the arbiter hands
   // the bus to a master with a different address or direction.
   always_comb begin
      req_match = (i_addr == last_addr) && (i_we == last_we);
      req_new   = i_cs && (!prev_cs || !req_match);
   end

   // Remember the previous cycle's chip select so a fresh assertion is seen.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         prev_cs <= 1'b0;
      end else begin
         prev_cs <= i_cs;
      end
   end

   // Cycle sequencer. Pad outputs are loaded with the values for the phase
   // being entered, so each phase sees its strobes from its first cycle on.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         last_addr    <= '0;
         last_we      <= 1'b0;
         o_ack        <= 1'b0;
         o_dat        <= '0;
         o_sram_addr  <= '0;
         o_sram_dq    <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
      end else begin
         o_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (req_new) begin
                  last_addr   <= i_addr;
                  last_we     <= i_we;
                  o_sram_addr <= ADDR_W'(i_addr);
                  o_sram_ce_n <= 1'b0;
                  if (i_we) begin
                     o_sram_dq    <= i_dat;
                     o_sram_dq_oe <= 1'b1;
                  end else begin
                     o_sram_oe_n <= 1'b0;
                  end
                  state <= SETUP;
               end
            end
            SETUP: begin
               wait_cnt <= WAIT_LOAD;
               if (last_we) begin
                  o_sram_we_n <= 1'b0;
               end
               state <= STROBE;
            end
            STROBE: begin
               if (wait_cnt == '0) begin
                  o_sram_we_n <= 1'b1;
                  o_sram_oe_n <= 1'b1;
                  if (!last_we) begin
                     o_dat <= i_sram_dq;
                  end
                  state <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt - CNT_ONE;
               end
            end
            HOLD: begin
               o_sram_ce_n  <= 1'b1;
               o_sram_dq_oe <= 1'b0;
               state        <= DONE;
            end
            DONE: begin
               o_ack <= i_cs && req_match;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: a behavioural SRAM model, a strobe
// monitor, an ack scoreboard, a vector table and a few multi-cycle sequences.
module tb_sram_bridge;

   localparam int W  = 1;
   localparam int AW = 16;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [15:0]   i_addr;
   logic [7:0]    i_dat;
   logic [7:0]    o_dat;
   logic          i_we;
   logic          i_cs;
   logic          o_ack;
   logic [AW-1:0] o_sram_addr;
   logic [7:0]    o_sram_dq;
   logic          o_sram_dq_oe;
   logic [7:0]    i_sram_dq;
   logic          o_sram_ce_n;
   logic          o_sram_oe_n;
   logic          o_sram_we_n;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   sram_bridge #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_addr       (i_addr),
      .i_dat        (i_dat),
      .o_dat        (o_dat),
      .i_we         (i_we),
      .i_cs         (i_cs),
      .o_ack        (o_ack),
      .o_sram_addr  (o_sram_addr),
      .o_sram_dq    (o_sram_dq),
      .o_sram_dq_oe (o_sram_dq_oe),
      .i_sram_dq    (i_sram_dq),
      .o_sram_ce_n  (o_sram_ce_n),
      .o_sram_oe_n  (o_sram_oe_n),
      .o_sram_we_n  (o_sram_we_n)
   );

   // SRAM contents: locations never written hold a fixed address pattern.
   logic [7:0] wr_mem [logic [15:0]];

   function automatic logic [7:0] romInit(input logic [15:0] a);
      return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
   endfunction

   function automatic logic [7:0] modelRead(input logic [15:0] a);
      return wr_mem.exists(a) ? wr_mem[a] : romInit(a);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Ack scoreboard: expected o_dat at each ack, in request order.
   logic [7:0] sb[$];
   logic [7:0] exp_odat = 8'h00;

   int ce_run = 0, we_run = 0, oe_run = 0;
   int ce_len = 0, we_len = 0, oe_len = 0, we_lead = 0;
   int ce_falls = 0, ack_cnt = 0, stable_err = 0;
   logic prev_ce_n = 1'b1, prev_we_n = 1'b1, prev_oe_n = 1'b1;
   logic [15:0] cyc_addr = '0;
   logic [7:0]  cyc_dq = '0;
   logic        cyc_wr = 1'b0;

   // Pad monitor and SRAM model, sampled on the falling edge when the
   // registered strobes are settled.
   always @(negedge i_clk) begin
      if (!o_sram_ce_n) begin
         if (prev_ce_n) begin
            ce_falls++;
            ce_run   = 0;
            cyc_addr = o_sram_addr;
            cyc_dq   = o_sram_dq;
            cyc_wr   = o_sram_dq_oe;
         end
         ce_run++;
         if (o_sram_addr !== cyc_addr) stable_err++;
         if (cyc_wr && ((o_sram_dq !== cyc_dq) || !o_sram_dq_oe)) stable_err++;
      end else if (!prev_ce_n) begin
         ce_len = ce_run;
      end
      if (!o_sram_we_n) begin
         if (prev_we_n) begin
            we_run  = 0;
            we_lead = ce_run - 1;
         end
         we_run++;
      end else if (!prev_we_n) begin
         we_len = we_run;
         if (!o_sram_ce_n) wr_mem[o_sram_addr] = o_sram_dq;
      end
      if (!o_sram_oe_n) begin
         if (prev_oe_n) oe_run = 0;
         oe_run++;
      end else if (!prev_oe_n) begin
         oe_len = oe_run;
      end
      if (o_ack === 1'b1) begin
         ack_cnt++;
         if (sb.size() == 0) begin
            checkOutput("sb_unexpected_ack", sb.size(), 1);
         end else begin
            checkOutput("sb_o_dat", o_dat, sb.pop_front());
         end
      end
      i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? modelRead(o_sram_addr) : 8'hEE;
      prev_ce_n = o_sram_ce_n;
      prev_we_n = o_sram_we_n;
      prev_oe_n = o_sram_oe_n;
   end

   task automatic applyStimulus(input logic we, input logic [15:0] addr,
                                input logic [7:0] dat, input logic [7:0] rd,
                                input bit expect_ack);
      @(negedge i_clk);
      i_cs   = 1'b1;
      i_we   = we;
      i_addr = addr;
      i_dat  = dat;
      if (!we) exp_odat = rd;
      if (expect_ack) sb.push_back(exp_odat);
   endtask

   task automatic waitAck(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk);
         n++;
         @(negedge i_clk);
         if (o_ack) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("ack_timeout", 32'(ok), 1);
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  dat;
      logic [7:0]  exp_dat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat;
      bit ok;
      int acks0, falls0;

      vecs[0] = '{1'b0, 16'h1234, 8'h00, 8'hA5};
      vecs[1] = '{1'b1, 16'hBEEF, 8'h5A, 8'h5A};
      vecs[2] = '{1'b0, 16'hBEEF, 8'h00, 8'h5A};
      vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'h3C};
      vecs[4] = '{1'b1, 16'hFFFF, 8'hC3, 8'hC3};
      vecs[5] = '{1'b0, 16'hFFFF, 8'h00, 8'hC3};
      vecs[6] = '{1'b1, 16'h0001, 8'h00, 8'h00};
      vecs[7] = '{1'b0, 16'h0001, 8'hFF, 8'h00};

      i_reset = 1'b1;
      i_cs    = 1'b0;
      i_we    = 1'b0;
      i_addr  = '0;
      i_dat   = '0;
      repeat (3) @(negedge i_clk);
      checkOutput("rst_ack", o_ack, 0);
      checkOutput("rst_o_dat", o_dat, 0);
      checkOutput("rst_ce_n", o_sram_ce_n, 1);
      checkOutput("rst_oe_n", o_sram_oe_n, 1);
      checkOutput("rst_we_n", o_sram_we_n, 1);
      checkOutput("rst_dq_oe", o_sram_dq_oe, 0);
      checkOutput("rst_addr", o_sram_addr, 0);
      checkOutput("rst_dq", o_sram_dq, 0);
      i_reset = 1'b0;
      repeat (2) @(negedge i_clk);

      $display("[TB] vector table");
      for (int v = 0; v < 8; v++) begin
         acks0 = ack_cnt;
         applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].dat, vecs[v].exp_dat, 1'b1);
         waitAck(lat, ok);
         checkOutput("latency", lat, W + 5);
         i_cs = 1'b0;
         repeat (3) @(negedge i_clk);
         checkOutput("ack_once", ack_cnt - acks0, 1);
         checkOutput("cycle_addr", cyc_addr, vecs[v].addr);
         checkOutput("ce_len", ce_len, W + 3);
         if (vecs[v].we) begin
            checkOutput("we_len", we_len, W + 1);
            checkOutput("we_lead", we_lead, 1);
            checkOutput("we_trail", ce_len - we_lead - we_len, 1);
            checkOutput("mem_write", modelRead(vecs[v].addr), vecs[v].exp_dat);
         end else begin
            checkOutput("oe_len", oe_len, W + 2);
         end
      end

      $display("[TB] chip select held after ack");
      acks0  = ack_cnt;
      falls0 = ce_falls;
      applyStimulus(1'b0, 16'h4444, 8'h00, 8'h3C, 1'b1);
      waitAck(lat, ok);
      repeat (10) @(negedge i_clk);
      checkOutput("hold_acks", ack_cnt - acks0, 1);
      checkOutput("hold_cycles", ce_falls - falls0, 1);
      i_cs = 1'b0;
      repeat (2) @(negedge i_clk);

      $display("[TB] master switch with chip select high");
      acks0  = ack_cnt;
      falls0 = ce_falls;
      applyStimulus(1'b0, 16'h0100, 8'h00, 8'h3D, 1'b1);
      waitAck(lat, ok);
      applyStimulus(1'b0, 16'h8000, 8'h00, 8'hBC, 1'b1);
      waitAck(lat, ok);
      checkOutput("switch_latency", lat, W + 5);
      i_cs = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("switch_acks", ack_cnt - acks0, 2);
      checkOutput("switch_cycles", ce_falls - falls0, 2);
      checkOutput("switch_addr", cyc_addr, 16'h8000);

      $display("[TB] chip select dropped during write strobe");
      acks0 = ack_cnt;
      applyStimulus(1'b1, 16'h2222, 8'h77, 8'h00, 1'b0);
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      i_cs = 1'b0;
      repeat (10) @(negedge i_clk);
      checkOutput("drop_acks", ack_cnt - acks0, 0);
      checkOutput("drop_we_len", we_len, W + 1);
      checkOutput("drop_mem", modelRead(16'h2222), 8'h77);
      checkOutput("drop_ce_n", o_sram_ce_n, 1);
      checkOutput("drop_o_dat", o_dat, exp_odat);
      applyStimulus(1'b0, 16'h2222, 8'h00, 8'h77, 1'b1);
      waitAck(lat, ok);
      checkOutput("drop_next_latency", lat, W + 5);
      i_cs = 1'b0;
      repeat (3) @(negedge i_clk);

      $display("[TB] reset during write strobe");
      applyStimulus(1'b1, 16'h3333, 8'h99, 8'h00, 1'b0);
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("pre_rst_we_n", o_sram_we_n, 0);
      i_reset = 1'b1;
      i_cs    = 1'b0;
      @(posedge i_clk);
      #1;
      checkOutput("mid_rst_we_n", o_sram_we_n, 1);
      checkOutput("mid_rst_ce_n", o_sram_ce_n, 1);
      checkOutput("mid_rst_dq_oe", o_sram_dq_oe, 0);
      checkOutput("mid_rst_oe_n", o_sram_oe_n, 1);
      @(negedge i_clk);
      i_reset  = 1'b0;
      exp_odat = 8'h00;
      checkOutput("mid_rst_o_dat", o_dat, 0);
      @(negedge i_clk);
      applyStimulus(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1);
      waitAck(lat, ok);
      checkOutput("post_rst_latency", lat, W + 5);
      i_cs = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("post_rst_o_dat", o_dat, 8'hA5);

      checkOutput("sb_empty", sb.size(), 0);
      checkOutput("pad_stability", stable_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
